// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Arbitrates an instruction-fetch port (imem) and a load/store port (dmem)
//   onto a single shared memory bus. Each port holds at most one pending
//   request. A small IDLE/IMEM/DMEM FSM grants the bus to one pending request
//   at a time. An optional grant-cycle timeout aborts stalled accesses.
//
// Parameters
//   DMEM_FIRST  1: dmem wins when both ports are pending, 0: imem wins
//   TIMEOUT     grant cycles before an access is aborted (0 = never)
//
// Ports
//   clk, reset                 clock, async active-high reset
//   imem_address/enable        fetch request (captured on enable)
//   imem_data, imem_wait       fetched word, fetch outstanding
//   dmem_address/enable        data request (captured on enable with rd|wr)
//   dmem_write_data/enable/mode  store request fields
//   dmem_read_enable/mode      load request fields
//   dmem_read_data, dmem_wait  raw load word, data access outstanding
//   bus_valid/write/mode/address/write_data  shared bus request
//   bus_read_data, bus_ready   bus response, ready completes the request
//   bus_error                  sticky timeout flag
module mem_arbiter #(
  parameter int DMEM_FIRST = 1,
  parameter int TIMEOUT    = 0
) (
  input  logic        clk,
  input  logic        reset,
  // fetch port
  input  logic [31:0] imem_address,
  input  logic        imem_enable,
  output logic [31:0] imem_data,
  output logic        imem_wait,
  // data port
  input  logic [31:0] dmem_address,
  input  logic        dmem_enable,
  input  logic [31:0] dmem_write_data,
  output logic [31:0] dmem_read_data,
  input  logic        dmem_write_enable,
  input  logic [2:0]  dmem_write_mode,
  input  logic        dmem_read_enable,
  input  logic [2:0]  dmem_read_mode,
  output logic        dmem_wait,
  // shared bus
  output logic        bus_valid,
  output logic        bus_write,
  output logic [2:0]  bus_mode,
  output logic [31:0] bus_address,
  output logic [31:0] bus_write_data,
  input  logic [31:0] bus_read_data,
  input  logic        bus_ready,
  output logic        bus_error
);

  typedef enum logic [1:0] {IDLE, IMEM, DMEM} state_t;

  typedef struct packed {
    logic        pend;
    logic [31:0] addr;
  } ireq_t;

  typedef struct packed {
    logic        pend;
    logic [31:0] addr;
    logic [31:0] data;
    logic        write;
    logic [2:0]  mode;
  } dreq_t;

  // Counter only has to reach TIMEOUT-1; keep at least one bit so the
  // design still elaborates with the timeout disabled.
  localparam int             CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]  TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [2:0]     FETCH_MODE = 3'b010;

  state_t        state;
  ireq_t         ireq;
  dreq_t         dreq;
  logic [CW-1:0] to_cnt;
  logic          err;

  logic          i_strobe, d_strobe;
  logic          granted, timed_out, done;
  logic          i_done, d_done;
  logic          i_cap, d_cap;
  logic          i_pend_nx, d_pend_nx;
  logic [31:0]   rd_word;

  always_comb begin
    i_strobe  = imem_enable;
    d_strobe  = dmem_enable && (dmem_read_enable || dmem_write_enable);
    granted   = (state != IDLE);
    // Timeout fires on the TIMEOUT-th grant cycle only if ready is absent,
    // so a ready arriving in that last cycle still returns real data.
    timed_out = (TIMEOUT > 0) && granted && !bus_ready && (to_cnt == TO_LAST);
    done      = granted && (bus_ready || timed_out);
    i_done    = done && (state == IMEM);
    d_done    = done && (state == DMEM);
    // A strobe is taken when the port is free, or on the very edge that
    // retires the port's current request.
    i_cap     = i_strobe && (!ireq.pend || i_done);
    d_cap     = d_strobe && (!dreq.pend || d_done);
    // Pending view used by IDLE arbitration: includes a strobe captured on
    // this same edge, so a fresh request is granted in the next cycle.
    i_pend_nx = ireq.pend || i_strobe;
    d_pend_nx = dreq.pend || d_strobe;
    rd_word   = timed_out ? 32'h0 : bus_read_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      ireq           <= '0;
      dreq           <= '0;
      imem_data      <= '0;
      dmem_read_data <= '0;
      err            <= 1'b0;
      to_cnt         <= '0;
    end else begin
      // request capture / retire
      if (i_cap) begin
        ireq.pend <= 1'b1;
        ireq.addr <= imem_address;
      end else if (i_done) begin
        ireq.pend <= 1'b0;
      end

      if (d_cap) begin
        dreq.pend  <= 1'b1;
        dreq.addr  <= dmem_address;
        dreq.data  <= dmem_write_data;
        dreq.write <= dmem_write_enable;
        dreq.mode  <= dmem_write_enable ? dmem_write_mode : dmem_read_mode;
      end else if (d_done) begin
        dreq.pend <= 1'b0;
      end

      // response data; stores leave the load register untouched
      if (i_done)                imem_data      <= rd_word;
      if (d_done && !dreq.write) dmem_read_data <= rd_word;
      if (timed_out)             err            <= 1'b1;

      unique case (state)
        IDLE: begin
          to_cnt <= '0;
          if (d_pend_nx && ((DMEM_FIRST != 0) || !i_pend_nx)) state <= DMEM;
          else if (i_pend_nx)                                  state <= IMEM;
        end
        IMEM, DMEM: begin
          // always pass through IDLE between grants
          if (done) begin
            state  <= IDLE;
            to_cnt <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus fields come straight from state and the pending registers, which
  // cannot change while granted, so they are stable until completion.
  always_comb begin
    bus_valid      = granted;
    bus_write      = 1'b0;
    bus_mode       = 3'b000;
    bus_address    = 32'h0;
    bus_write_data = 32'h0;
    if (state == DMEM) begin
      bus_write      = dreq.write;
      bus_mode       = dreq.mode;
      bus_address    = dreq.addr;
      bus_write_data = dreq.data;
    end else if (state == IMEM) begin
      bus_mode       = FETCH_MODE;
      bus_address    = ireq.addr;
    end
  end

  assign imem_wait = ireq.pend;
  assign dmem_wait = dreq.pend;
  assign bus_error = err;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_address, imem_data;
  logic        imem_enable, imem_wait;
  logic [31:0] dmem_address, dmem_write_data, dmem_read_data;
  logic        dmem_enable, dmem_write_enable, dmem_read_enable, dmem_wait;
  logic [2:0]  dmem_write_mode, dmem_read_mode;
  logic        bus_valid, bus_write, bus_ready, bus_error;
  logic [2:0]  bus_mode;
  logic [31:0] bus_address, bus_write_data, bus_read_data;

  mem_arbiter #(.DMEM_FIRST(1), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .imem_address(imem_address), .imem_enable(imem_enable),
    .imem_data(imem_data), .imem_wait(imem_wait),
    .dmem_address(dmem_address), .dmem_enable(dmem_enable),
    .dmem_write_data(dmem_write_data), .dmem_read_data(dmem_read_data),
    .dmem_write_enable(dmem_write_enable), .dmem_write_mode(dmem_write_mode),
    .dmem_read_enable(dmem_read_enable), .dmem_read_mode(dmem_read_mode),
    .dmem_wait(dmem_wait),
    .bus_valid(bus_valid), .bus_write(bus_write), .bus_mode(bus_mode),
    .bus_address(bus_address), .bus_write_data(bus_write_data),
    .bus_read_data(bus_read_data), .bus_ready(bus_ready), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // one expected bus transaction
  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  mode;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          cycles;
    bit          tmo;
    int          issue;
    int          lat;
  } exp_t;

  exp_t iq[$];
  exp_t dq[$];

  // bus slave behaviour knobs
  int          force_delay = 0;
  bit          ovr_en = 1'b0;
  logic [31:0] ovr_val = 32'h0;

  // number of grant cycles the slave stalls before asserting ready
  function automatic int dly_of(input logic [31:0] a);
    logic [2:0] b;
    if (force_delay >= 0) return force_delay;
    b = a[4:2];
    return (b >= 3'd6) ? 5 : int'(b[1:0]);
  endfunction

  function automatic logic [31:0] rd_of(input logic [31:0] a);
    if (ovr_en) return ovr_val;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr_strobes();
    imem_enable       = 1'b0;
    dmem_enable       = 1'b0;
    dmem_read_enable  = 1'b0;
    dmem_write_enable = 1'b0;
  endtask

  function automatic exp_t mk_exp(input logic [31:0] a, input logic wr,
                                  input logic [2:0] md, input logic [31:0] wd,
                                  input int lat);
    exp_t e;
    int d;
    d       = dly_of(a);
    e.addr  = a;
    e.wr    = wr;
    e.mode  = md;
    e.wdata = wd;
    e.tmo   = (d + 1 > TMO);
    e.cycles = e.tmo ? TMO : d + 1;
    e.rdata = e.tmo ? 32'h0 : rd_of(a);
    e.issue = cyc;
    e.lat   = lat;
    return e;
  endfunction

  task automatic push_i(input logic [31:0] a, input int lat);
    iq.push_back(mk_exp(a, 1'b0, 3'b010, 32'h0, lat));
    imem_enable  = 1'b1;
    imem_address = a;
  endtask

  task automatic push_d(input logic [31:0] a, input logic wr, input logic [2:0] md,
                        input logic [31:0] wd, input int lat);
    logic [31:0] r;
    dq.push_back(mk_exp(a, wr, md, wd, lat));
    r = $urandom;
    dmem_enable     = 1'b1;
    dmem_address    = a;
    dmem_write_data = wd;
    if (wr) begin
      // read_enable randomly set too: the write must take precedence
      dmem_write_enable = 1'b1;
      dmem_read_enable  = r[0];
      dmem_write_mode   = md;
      dmem_read_mode    = r[3:1];
    end else begin
      dmem_write_enable = 1'b0;
      dmem_read_enable  = 1'b1;
      dmem_read_mode    = md;
      dmem_write_mode   = r[3:1];
    end
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while ((iq.size() != 0 || dq.size() != 0 || imem_wait || dmem_wait || bus_valid) && k < 80) begin
      tick(1);
      k++;
    end
    chk(nm, 32'(k < 80), 32'd1);
    tick(2);
  endtask

  // bus slave: stalls dly_of(addr) grant cycles, random noise otherwise
  initial begin
    int g;
    logic [31:0] r;
    g = 0;
    bus_ready = 1'b0;
    bus_read_data = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      r = $urandom;
      if (bus_valid) begin
        g++;
        bus_ready     = (g == dly_of(bus_address) + 1);
        bus_read_data = bus_ready ? rd_of(bus_address) : r;
      end else begin
        g = 0;
        bus_ready     = r[0];
        bus_read_data = $urandom;
      end
    end
  end

  // monitor / scoreboard
  initial begin
    bit          pv, have, cport;
    exp_t        cur;
    int          n;
    logic [31:0] m_idata, m_ddata;
    bit          m_err;
    pv = 0; have = 0; cport = 0; n = 0;
    m_idata = 0; m_ddata = 0; m_err = 0;
    forever begin
      @(negedge clk or posedge reset);
      if (reset) begin
        pv = 0; have = 0; n = 0;
        m_idata = 0; m_ddata = 0; m_err = 0;
        continue;
      end
      if (bus_valid && !pv) begin
        n = 0;
        if (dq.size() > 0 && bus_address == dq[0].addr) begin
          cur = dq.pop_front(); cport = 1; have = 1;
        end else if (iq.size() > 0 && bus_address == iq[0].addr) begin
          cur = iq.pop_front(); cport = 0; have = 1;
        end else begin
          have = 0;
          chk("grant_expected", bus_address, (dq.size() > 0) ? dq[0].addr :
                                             (iq.size() > 0) ? iq[0].addr : 32'hxxxx_xxxx);
        end
        if (have && cur.lat >= 0) chk("grant_lat", 32'(cyc - cur.issue), 32'(cur.lat));
      end
      if (bus_valid && have) begin
        n++;
        chk("bus_address", bus_address, cur.addr);
        chk("bus_write", 32'(bus_write), 32'(cur.wr));
        chk("bus_mode", 32'(bus_mode), 32'(cur.mode));
        if (cur.wr) chk("bus_wdata", bus_write_data, cur.wdata);
      end
      if (!bus_valid && pv && have) begin
        chk("valid_cycles", 32'(n), 32'(cur.cycles));
        if (cur.tmo) m_err = 1;
        if (cport) begin
          if (!cur.wr) m_ddata = cur.rdata;
          chk("dmem_wait_lo", 32'(dmem_wait), 32'd0);
          chk("dmem_read_data", dmem_read_data, m_ddata);
          chk("imem_data_hold", imem_data, m_idata);
        end else begin
          m_idata = cur.rdata;
          chk("imem_wait_lo", 32'(imem_wait), 32'd0);
          chk("imem_data", imem_data, m_idata);
          chk("dmem_data_hold", dmem_read_data, m_ddata);
        end
        chk("bus_error", 32'(bus_error), 32'(m_err));
        have = 0;
      end
      pv = bus_valid;
    end
  end

  task automatic imem_drv(input int n);
    logic [31:0] a;
    int k;
    for (int t = 0; t < n; t++) begin
      tick($urandom_range(0, 3));
      a = $urandom & 32'h0000_fffc;
      push_i(a, -1);
      tick(1);
      imem_enable  = 1'b0;
      imem_address = $urandom;
      k = 0;
      while (imem_wait && k < 40) begin tick(1); k++; end
      chk("i_drain", 32'(k < 40), 32'd1);
    end
  endtask

  task automatic dmem_drv(input int n);
    logic [31:0] a, r;
    int k, w;
    for (int t = 0; t < n; t++) begin
      w = $urandom_range(0, 3);
      // decoy strobes without read/write enable must not be captured
      repeat (w) begin
        r = $urandom;
        dmem_enable       = r[0];
        dmem_read_enable  = 1'b0;
        dmem_write_enable = 1'b0;
        dmem_address      = 32'h2000_0000 | ($urandom & 32'h0000_fffc);
        tick(1);
      end
      r = $urandom;
      a = 32'h1000_0000 | ($urandom & 32'h0000_fffc);
      push_d(a, r[0], r[3:1], $urandom, -1);
      tick(1);
      dmem_enable       = 1'b0;
      dmem_read_enable  = 1'b0;
      dmem_write_enable = 1'b0;
      k = 0;
      while (dmem_wait && k < 40) begin tick(1); k++; end
      chk("d_drain", 32'(k < 40), 32'd1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    imem_address = 0; dmem_address = 0; dmem_write_data = 0;
    dmem_write_mode = 0; dmem_read_mode = 0;
    clr_strobes();

    // reset state
    #3;
    chk("rst_bus_valid", 32'(bus_valid), 32'd0);
    chk("rst_imem_wait", 32'(imem_wait), 32'd0);
    chk("rst_dmem_wait", 32'(dmem_wait), 32'd0);
    chk("rst_imem_data", imem_data, 32'd0);
    chk("rst_dmem_data", dmem_read_data, 32'd0);
    chk("rst_bus_error", 32'(bus_error), 32'd0);
    tick(3);
    reset = 1'b0;
    tick(2);

    // single fetch, minimum latency
    force_delay = 0; ovr_en = 1'b1; ovr_val = 32'h0000_0013;
    push_i(32'h10, 1);
    tick(1);
    clr_strobes();
    chk("fetch_wait_hi", 32'(imem_wait), 32'd1);
    wait_idle("fetch_drain");
    ovr_en = 1'b0;

    // simultaneous load + fetch, dmem first
    push_d(32'h100, 1'b0, 3'b010, 32'h0, 1);
    push_i(32'h20, 3);
    tick(1);
    clr_strobes();
    wait_idle("prio_drain");

    // store stalled: valid for 3 cycles
    force_delay = 2;
    push_d(32'h200, 1'b1, 3'b000, 32'hDEAD_BEEF, 1);
    tick(1);
    clr_strobes();
    wait_idle("store_drain");

    // timeout: ready never comes
    force_delay = 7;
    push_i(32'h40, 1);
    tick(1);
    clr_strobes();
    wait_idle("tmo_drain");
    tick(3);
    chk("err_sticky", 32'(bus_error), 32'd1);

    // re-strobe while pending; ready in the last allowed grant cycle
    force_delay = 3;
    push_i(32'h50, 1);
    tick(1);
    imem_address = 32'h54;
    tick(2);
    clr_strobes();
    wait_idle("restrobe_drain");

    // reset in the second cycle of a stalled load
    force_delay = 7;
    push_d(32'h300, 1'b0, 3'b010, 32'h0, 1);
    tick(1);
    clr_strobes();
    tick(1);
    #1 reset = 1'b1;
    #1;
    chk("midrst_bus_valid", 32'(bus_valid), 32'd0);
    chk("midrst_dmem_wait", 32'(dmem_wait), 32'd0);
    chk("midrst_dmem_data", dmem_read_data, 32'd0);
    chk("midrst_bus_error", 32'(bus_error), 32'd0);
    #1 reset = 1'b0;
    tick(2);
    force_delay = 0;
    push_d(32'h304, 1'b0, 3'b001, 32'h0, 1);
    tick(1);
    clr_strobes();
    wait_idle("postrst_drain");

    // randomized concurrent traffic
    force_delay = -1;
    fork
      imem_drv(40);
      dmem_drv(40);
    join
    clr_strobes();
    wait_idle("rand_drain");
    chk("iq_empty", 32'(iq.size()), 32'd0);
    chk("dq_empty", 32'(dq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
